mul_fu_scheduler: RTL and testbench

- Issue and writeback controller for the 32-bit Wallace multiplier functional unit in the Tomasulo core.
- Arbitrates round-robin between multiply reservation stations and launches one operation at a time into the combinational multiplier.
- Holds operands stable for a fixed multicycle window, then captures the 64-bit product into a 2-entry result buffer.
- Drains the buffer onto the common data bus (CDB) with a request/grant handshake.

---
 rtl/mul_fu_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_mul_fu_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_fu_scheduler.sv
// Issue/writeback controller for the Wallace multiplier FU: round-robin issue,
// multicycle hold, 2-entry result FIFO to the CDB. `MUL_FLUSH_EN adds a flush port.
module mul_fu_scheduler #(
    parameter int NUM_RS = 3,
    parameter int TAG_W  = 4,
    parameter int LAT    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_RS-1:0]       rs_req,
    input  logic [NUM_RS*TAG_W-1:0] rs_tag,
    input  logic [NUM_RS*32-1:0]    rs_a,
    input  logic [NUM_RS*32-1:0]    rs_b,
    output logic [NUM_RS-1:0]       rs_grant,
    output logic [31:0]             mul_a,
    output logic [31:0]             mul_b,
    input  logic [63:0]             mul_product,
    output logic                    busy,
    output logic                    cdb_req,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [63:0]             cdb_data,
`ifdef MUL_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic                    cdb_grant
);
    localparam int IW = $clog2(NUM_RS);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] t0_q, t0_d, t1_q, t1_d;
    logic [63:0]      p0_q, p0_d, p1_q, p1_d;

    logic          kill;
    logic          found;
    logic [IW-1:0] sel;
    logic [IW:0]   idx;
    logic          legal;
    logic          push;
    logic          pop;

`ifdef MUL_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            idx = {1'b0, ptr_q} + (IW+1)'(k);
            if (idx >= (IW+1)'(NUM_RS))
                idx = idx - (IW+1)'(NUM_RS);
            if (!found && rs_req[idx[IW-1:0]]) begin
                found = 1'b1;
                sel   = idx[IW-1:0];
            end
        end
    end

    assign legal = (state_q == IDLE) && found && (occ_q != 2'd2)
                   && !rst && !kill;
    assign push  = (state_q == BUSY) && (cnt_q == '0) && !kill;
    assign pop   = cdb_req && cdb_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (legal) begin
                    state_d = BUSY;
                    cnt_d   = CW'(LAT - 1);
                end
            end
            BUSY: begin
                if (cnt_q == '0)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q - CW'(1);
            end
        endcase
        if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        rs_grant = '0;
        if (legal)
            rs_grant[sel] = 1'b1;
        busy = (state_q == BUSY);
    end

    always_comb begin
        ptr_d = ptr_q;
        a_d   = a_q;
        b_d   = b_q;
        tag_d = tag_q;
        if (legal) begin
            ptr_d = (sel == IW'(NUM_RS - 1)) ? '0 : sel + IW'(1);
            a_d   = rs_a[sel*32 +: 32];
            b_d   = rs_b[sel*32 +: 32];
            tag_d = rs_tag[sel*TAG_W +: TAG_W];
        end
    end

    // Entry 0 is the head; a push lands behind whatever survives the pop.
    always_comb begin
        t0_d = t0_q;
        p0_d = p0_q;
        t1_d = t1_q;
        p1_d = p1_q;
        if (pop) begin
            t0_d = t1_q;
            p0_d = p1_q;
        end
        if (push) begin
            if (occ_q == 2'd0 || (pop && occ_q == 2'd1)) begin
                t0_d = tag_q;
                p0_d = mul_product;
            end else begin
                t1_d = tag_q;
                p1_d = mul_product;
            end
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        if (kill)
            occ_d = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
            occ_q <= '0;
            t0_q  <= '0;
            p0_q  <= '0;
            t1_q  <= '0;
            p1_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            a_q   <= a_d;
            b_q   <= b_d;
            tag_q <= tag_d;
            occ_q <= occ_d;
            t0_q  <= t0_d;
            p0_q  <= p0_d;
            t1_q  <= t1_d;
            p1_q  <= p1_d;
        end
    end

    assign mul_a    = a_q;
    assign mul_b    = b_q;
    assign cdb_req  = (occ_q != 2'd0);
    assign cdb_tag  = t0_q;
    assign cdb_data = p0_q;

endmodule

// File: tb/tb_mul_fu_scheduler.sv
// Directed bench for mul_fu_scheduler: per-cycle vector table plus
// hand-written latency and flush sequences.
module tb_mul_fu_scheduler;
    localparam int NRS = 3;
    localparam int TW  = 4;
    localparam int LAT = 3;
    localparam logic [63:0] BIG = 64'hFFFFFFFE00000001;

    logic              clk;
    logic              rst;
    logic [NRS-1:0]    rs_req;
    logic [NRS*TW-1:0] rs_tag;
    logic [NRS*32-1:0] rs_a;
    logic [NRS*32-1:0] rs_b;
    logic [NRS-1:0]    rs_grant;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic [63:0]       mul_product;
    logic              busy;
    logic              cdb_req;
    logic [TW-1:0]     cdb_tag;
    logic [63:0]       cdb_data;
    logic              cdb_grant;
`ifdef MUL_FLUSH_EN
    logic              flush;
`endif

    typedef struct {
        logic           rst;
        logic [2:0]     req;
        logic           cg;
        logic [2:0]     g;
        logic           b;
        logic           cr;
        logic           dchk;
        logic [3:0]     tag;
        logic [63:0]    data;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;
    int   lat;

    mul_fu_scheduler #(.NUM_RS(NRS), .TAG_W(TW), .LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .rs_req      (rs_req),
        .rs_tag      (rs_tag),
        .rs_a        (rs_a),
        .rs_b        (rs_b),
        .rs_grant    (rs_grant),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .busy        (busy),
        .cdb_req     (cdb_req),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
`ifdef MUL_FLUSH_EN
        .flush       (flush),
`endif
        .cdb_grant   (cdb_grant)
    );

    // Stand-in for the combinational Wallace array.
    assign mul_product = 64'(mul_a) * 64'(mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [2:0] q, input logic c,
                       input logic [2:0] g, input logic b, input logic cr,
                       input logic dk, input logic [3:0] t,
                       input logic [63:0] d);
        vec_t v;
        v.rst = r; v.req = q; v.cg = c; v.g = g; v.b = b;
        v.cr = cr; v.dchk = dk; v.tag = t; v.data = d;
        tbl.push_back(v);
    endtask

    initial begin
        rst       = 1'b1;
        rs_req    = '0;
        cdb_grant = 1'b0;
`ifdef MUL_FLUSH_EN
        flush     = 1'b0;
`endif
        rs_tag = {4'd9, 4'd5, 4'd2};
        rs_a   = {32'hFFFFFFFF, 32'd7, 32'd3};
        rs_b   = {32'hFFFFFFFF, 32'd9, 32'd4};

        // rst req cg | grant busy creq dchk tag data
        add(1, 3'b000, 0, 3'b000, 0, 0, 1, 0, 0);
        add(1, 3'b111, 1, 3'b000, 0, 0, 1, 0, 0);
        add(0, 3'b010, 0, 3'b010, 0, 0, 1, 0, 0);
        add(0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 1, 3'b000, 0, 1, 1, 5, 63);
        add(0, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0);
        add(0, 3'b001, 0, 3'b001, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 0);
        // backpressure: two buffered, third held off
        add(0, 3'b111, 0, 3'b010, 0, 1, 1, 2, 12);
        add(0, 3'b111, 0, 3'b000, 1, 1, 1, 2, 12);
        add(0, 3'b111, 0, 3'b000, 1, 1, 1, 2, 12);
        add(0, 3'b111, 0, 3'b000, 1, 1, 1, 2, 12);
        add(0, 3'b111, 0, 3'b000, 0, 1, 1, 2, 12);
        add(0, 3'b111, 1, 3'b000, 0, 1, 1, 2, 12);
        add(0, 3'b111, 0, 3'b100, 0, 1, 1, 5, 63);
        add(0, 3'b000, 0, 3'b000, 1, 1, 1, 5, 63);
        add(0, 3'b000, 0, 3'b000, 1, 1, 1, 5, 63);
        // push with pop on the same edge
        add(0, 3'b000, 1, 3'b000, 1, 1, 1, 5, 63);
        add(0, 3'b000, 0, 3'b000, 0, 1, 1, 9, BIG);
        add(0, 3'b000, 1, 3'b000, 0, 1, 1, 9, BIG);
        // fairness after reset
        add(1, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0);
        add(0, 3'b111, 1, 3'b001, 0, 0, 1, 0, 0);
        add(0, 3'b111, 1, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b111, 1, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b111, 1, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b111, 1, 3'b010, 0, 1, 1, 2, 12);
        add(0, 3'b111, 1, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b111, 1, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b111, 1, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b111, 1, 3'b100, 0, 1, 1, 5, 63);
        add(0, 3'b111, 1, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b111, 1, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b111, 1, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b111, 1, 3'b001, 0, 1, 1, 9, BIG);
        // reset two cycles into an operation
        add(0, 3'b000, 1, 3'b000, 1, 0, 0, 0, 0);
        add(1, 3'b000, 1, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b011, 1, 3'b001, 0, 0, 1, 0, 0);
        add(0, 3'b000, 1, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 1, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 1, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 1, 3'b000, 0, 1, 1, 2, 12);
        add(0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            rst       = tbl[i].rst;
            rs_req    = tbl[i].req;
            cdb_grant = tbl[i].cg;
            @(negedge clk);
            check($sformatf("r%0d grant", i), 64'(rs_grant), 64'(tbl[i].g));
            check($sformatf("r%0d busy", i), 64'(busy), 64'(tbl[i].b));
            check($sformatf("r%0d cdb_req", i), 64'(cdb_req), 64'(tbl[i].cr));
            if (tbl[i].cr || tbl[i].dchk) begin
                check($sformatf("r%0d tag", i), 64'(cdb_tag), 64'(tbl[i].tag));
                check($sformatf("r%0d data", i), cdb_data, tbl[i].data);
            end
        end

        // Issue-to-CDB latency and operand hold, pointer at 1.
        @(posedge clk);
        #1;
        rs_req    = 3'b010;
        cdb_grant = 1'b0;
        @(negedge clk);
        check("seq grant", 64'(rs_grant), 64'(3'b010));
        @(posedge clk);
        #1;
        rs_req = 3'b000;
        lat = -1;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 2) begin
                check("seq mul_a", 64'(mul_a), 64'd7);
                check("seq mul_b", 64'(mul_b), 64'd9);
                check("seq busy", 64'(busy), 64'd1);
            end
            if (cdb_req)
                lat = c;
            @(posedge clk);
            #1;
        end
        check("seq latency", 64'(lat), 64'(LAT + 1));
        cdb_grant = 1'b1;
        @(negedge clk);
        check("seq head tag", 64'(cdb_tag), 64'd5);
        check("seq head data", cdb_data, 64'd63);
        @(posedge clk);
        #1;
        cdb_grant = 1'b0;
        @(negedge clk);
        check("seq drained", 64'(cdb_req), 64'd0);

`ifdef MUL_FLUSH_EN
        // Pointer is at 2; station 0 wins by wrap-around.
        rs_a[31:0] = 32'hFFFFFFFF;
        rs_b[31:0] = 32'd2;
        @(posedge clk);
        #1;
        rs_req = 3'b001;
        @(negedge clk);
        check("fl grant", 64'(rs_grant), 64'(3'b001));
        @(posedge clk);
        #1;
        rs_req = 3'b000;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush  = 1'b1;
        rs_req = 3'b001;
        @(negedge clk);
        check("fl busy", 64'(busy), 64'd1);
        check("fl grant0", 64'(rs_grant), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("fl idle", 64'(busy), 64'd0);
        check("fl no req", 64'(cdb_req), 64'd0);
        check("fl regrant", 64'(rs_grant), 64'(3'b001));
        check("fl mul_a", 64'(mul_a), 64'hFFFFFFFF);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("fl gnt forced", 64'(rs_grant), 64'd0);
        @(posedge clk);
        #1;
        flush  = 1'b0;
        rs_req = 3'b000;
        @(negedge clk);
        check("fl busy2", 64'(busy), 64'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("fl quiet%0d", c), 64'(cdb_req), 64'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
